mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage MIPS pipeline. It consumes the EX/MEM pipeline register outputs (MEM_*), performs word loads and stores against an internal data memory with a configurable wait-state count, and drives the MEM/WB pipeline register (WB_*) for write-back and forwarding. While a multi-cycle access is in progress it raises `Mem_Stall` to the hazard unit, and it inserts bubbles into MEM/WB.

## Interface

Parameters:

- `DEPTH_WORDS`, 256: data memory depth in 32-bit words; must be a power of two.
- `WAIT_STATES`, 2: extra cycles per memory access, 0..15. A value of 0 means a single-cycle access.

Ports (one clock; `reset` is synchronous and active-high):

- `clk`  in  1  pipeline clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `MEM_MemRead`  in  1  load request.
- `MEM_MemWrite`  in  1  store request.
- `MEM_MemtoReg`  in  1  write-back selects memory data.
- `MEM_RegWrite`  in  1  instruction writes the register file.
- `MEM_RegDst`  in  5  destination register number.
- `MEM_ALUResult`  in  32  byte address, or ALU result for non-memory instructions.
- `MEM_ReadData2`  in  32  store data.
- `Mem_Stall`  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM.
- `WB_RegWrite`  out  1  registered.
- `WB_MemtoReg`  out  1  registered.
- `WB_RegDst`  out  5  registered.
- `WB_ALUResult`  out  32  registered.
- `WB_ReadData`  out  32  registered load data.
- `WB_WriteData`  out  32  registered; equals `WB_MemtoReg ? WB_ReadData : WB_ALUResult`; used for forwarding.
- `Mem_Misaligned`  out  1  registered one-cycle error pulse.

## Operation

**Access and alignment**
- An access is `MEM_MemRead | MEM_MemWrite`.
- The access is aligned when `MEM_ALUResult[1:0] == 2'b00`.
- Word index is `MEM_ALUResult[log2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored, so addresses wrap modulo `DEPTH_WORDS*4`.

**State machine** (states IDLE and WAIT; 4-bit counter `cnt`):
- IDLE with an aligned access and `WAIT_STATES > 0`: `Mem_Stall = 1`; next state WAIT; `cnt <= WAIT_STATES-1`.
- IDLE with an aligned access and `WAIT_STATES == 0`: complete in this cycle; stay in IDLE.
- IDLE with a non-access or a misaligned access: complete in this cycle with no stall.
- WAIT with `cnt != 0`: `Mem_Stall = 1`; `cnt <= cnt-1`.
- WAIT with `cnt == 0`: `Mem_Stall = 0`; complete; next state IDLE.

**Completion cycle** (all effects at the posedge ending the cycle):
- Store: `mem[index] <= MEM_ReadData2`.
- Load: `WB_ReadData <= mem[index]`. The read uses the pre-write contents.
- If MemRead and MemWrite are both set, both actions occur: the write commits and the read returns the old word.
- MEM/WB captures the `MEM_*` control signals, `MEM_RegDst` and `MEM_ALUResult`, and computes `WB_WriteData`.
- For non-load completions, `WB_ReadData` is 0.

**Stall cycles** (`Mem_Stall = 1`):
- MEM/WB loads a bubble: `WB_RegWrite = 0`, `WB_MemtoReg = 0`, all data fields 0.
- No memory write occurs.
- The `MEM_*` inputs are held stable by upstream; the block does not latch them.

**Misaligned access**
- No memory write and no stall.
- MEM/WB loads a bubble.
- `Mem_Misaligned` is 1 for exactly the next cycle.

**Reset**
- All WB_* outputs and `Mem_Misaligned` are cleared to 0; state goes to IDLE; `cnt` is cleared to 0.
- Memory contents are not reset.
- Reset during WAIT abandons the access; a pending store is not committed.

## Timing

- Access presented in cycle t: `Mem_Stall` is high in cycles t .. t+WAIT_STATES-1.
- Completion occurs at the posedge ending cycle t+WAIT_STATES; WB_* show the result in cycle t+WAIT_STATES+1.
- Non-memory instructions take one cycle to MEM/WB with no stall.
- Back-to-back accesses: the second access sees state IDLE in the cycle after the first completes, so each access costs `WAIT_STATES+1` cycles.
- `Mem_Stall` depends combinationally on the `MEM_*` inputs and the state only; there is no path from `Mem_Stall` back to itself.

## Test plan

- **Store then load, WAIT_STATES=2:** sw `0xDEADBEEF` to address `0x10`, then lw r5 from `0x10` -> `Mem_Stall` high for 2 cycles per access; lw completes with `WB_RegWrite=1`, `WB_RegDst=5`, `WB_ReadData=WB_WriteData=0xDEADBEEF`; bubbles during stalls have `WB_RegWrite=0`.
- **WAIT_STATES=0, back-to-back:** sw `0x1234` to `0x4`, then lw from `0x4` the next cycle -> `Mem_Stall` never asserts; lw returns `0x1234` one cycle after it is presented.
- **Misaligned:** lw from `0x13` -> no stall; `WB_RegWrite=0`; `Mem_Misaligned=1` for one cycle; memory unchanged (verified by a following aligned read of `0x10`).
- **Reset mid-wait:** sw `0xAAAA5555` to `0x20` with WAIT_STATES=3, `reset` asserted in the second stall cycle -> all outputs 0 next cycle; `Mem_Stall=0`; a later lw from `0x20` returns the prior contents.
- **ALU pass-through:** R-type with `MEM_RegWrite=1`, `MEM_ALUResult=0x7F`, `MEM_RegDst=9` -> no stall; next cycle `WB_WriteData=0x7F`, `WB_RegDst=9`.
- **Wrap-around, DEPTH_WORDS=256:** sw `0x55` to `0x400`, lw from `0x000` -> returns `0x55`.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS memory-access stage: word load/store against a local data RAM with
// a configurable wait-state count, feeding the MEM/WB pipeline register.
module mem_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_MemtoReg,
  input  logic        MEM_RegWrite,
  input  logic [4:0]  MEM_RegDst,
  input  logic [31:0] MEM_ALUResult,
  input  logic [31:0] MEM_ReadData2,
  output logic        Mem_Stall,
  output logic        WB_RegWrite,
  output logic        WB_MemtoReg,
  output logic [4:0]  WB_RegDst,
  output logic [31:0] WB_ALUResult,
  output logic [31:0] WB_ReadData,
  output logic [31:0] WB_WriteData,
  output logic        Mem_Misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LP_LOAD =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic LP_HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_access;
  logic          w_aligned;
  logic          w_misacc;
  logic          w_take;
  logic [AW-1:0] w_idx;
  logic [31:0]   w_ld;
  logic          w_unused;

  assign w_access  = MEM_MemRead | MEM_MemWrite;
  assign w_aligned = (MEM_ALUResult[1:0] == 2'b00);
  assign w_misacc  = w_access & ~w_aligned;
  assign w_idx     = MEM_ALUResult[AW+1:2];
  assign w_unused  = &{1'b0, MEM_ALUResult[31:AW+2]};

  assign Mem_Stall = (r_state == S_IDLE)
    ? (w_access & w_aligned & LP_HAS_WAIT)
    : (r_cnt != 4'd0);

  // Results are taken only when the access (if any) finishes and is legal.
  assign w_take = ~Mem_Stall & ~w_misacc;
  assign w_ld   = MEM_MemRead ? r_mem[w_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (!reset && w_take && MEM_MemWrite)
      r_mem[w_idx] <= MEM_ReadData2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      WB_RegWrite    <= 1'b0;
      WB_MemtoReg    <= 1'b0;
      WB_RegDst      <= 5'd0;
      WB_ALUResult   <= 32'd0;
      WB_ReadData    <= 32'd0;
      WB_WriteData   <= 32'd0;
      Mem_Misaligned <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (Mem_Stall) begin
            r_state <= S_WAIT;
            r_cnt   <= LP_LOAD;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
          else r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      Mem_Misaligned <= ~Mem_Stall & w_misacc;

      if (w_take) begin
        WB_RegWrite  <= MEM_RegWrite;
        WB_MemtoReg  <= MEM_MemtoReg;
        WB_RegDst    <= MEM_RegDst;
        WB_ALUResult <= MEM_ALUResult;
        WB_ReadData  <= w_ld;
        WB_WriteData <= MEM_MemtoReg ? w_ld : MEM_ALUResult;
      end else begin
        WB_RegWrite  <= 1'b0;
        WB_MemtoReg  <= 1'b0;
        WB_RegDst    <= 5'd0;
        WB_ALUResult <= 32'd0;
        WB_ReadData  <= 32'd0;
        WB_WriteData <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (2, 0 and 3 wait states) driven
// from a vector table plus directed multi-cycle sequences.
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rd [3];
  logic        wr [3];
  logic        mtr [3];
  logic        rw [3];
  logic [4:0]  dst [3];
  logic [31:0] alu [3];
  logic [31:0] wd [3];

  logic        stall [3];
  logic        orw [3];
  logic        omtr [3];
  logic [4:0]  odst [3];
  logic [31:0] oalu [3];
  logic [31:0] ordata [3];
  logic [31:0] owdata [3];
  logic        omis [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage #(
      .DEPTH_WORDS(256),
      .WAIT_STATES(g == 0 ? 2 : (g == 1 ? 0 : 3))
    ) u_dut (
      .clk(clk),
      .reset(reset),
      .MEM_MemRead(rd[g]),
      .MEM_MemWrite(wr[g]),
      .MEM_MemtoReg(mtr[g]),
      .MEM_RegWrite(rw[g]),
      .MEM_RegDst(dst[g]),
      .MEM_ALUResult(alu[g]),
      .MEM_ReadData2(wd[g]),
      .Mem_Stall(stall[g]),
      .WB_RegWrite(orw[g]),
      .WB_MemtoReg(omtr[g]),
      .WB_RegDst(odst[g]),
      .WB_ALUResult(oalu[g]),
      .WB_ReadData(ordata[g]),
      .WB_WriteData(owdata[g]),
      .Mem_Misaligned(omis[g])
    );
  end

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        rd, wr, mtr, rw;
    logic [4:0]  dst;
    logic [31:0] alu, wd;
    logic        e_rw, e_mtr;
    logic [4:0]  e_dst;
    logic [31:0] e_alu, e_rd, e_wdata;
    logic        e_mis;
  } vec_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    else
      n_pass++;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int k, logic r, logic w, logic m, logic g,
                     logic [4:0] d, logic [31:0] a, logic [31:0] dat);
    rd[k] = r; wr[k] = w; mtr[k] = m; rw[k] = g;
    dst[k] = d; alu[k] = a; wd[k] = dat;
  endtask

  task automatic nop(int k);
    drv(k, 0, 0, 0, 0, 5'd0, 32'd0, 32'd0);
  endtask

  // Present an instruction and hold it; expects ws stall cycles with bubbles,
  // returns just after the completing edge.
  task automatic acc(int k, int ws, logic r, logic w, logic m, logic g,
                     logic [4:0] d, logic [31:0] a, logic [31:0] dat);
    drv(k, r, w, m, g, d, a, dat);
    for (int c = 0; c <= ws; c++) begin
      #1;
      chk($sformatf("stall_i%0d_c%0d", k, c), 32'(stall[k]), 32'(c < ws));
      nxt();
      if (c < ws) begin
        chk($sformatf("bub_rw_i%0d_c%0d", k, c), 32'(orw[k]), 32'd0);
        chk($sformatf("bub_wd_i%0d_c%0d", k, c), owdata[k], 32'd0);
        chk($sformatf("bub_mis_i%0d_c%0d", k, c), 32'(omis[k]), 32'd0);
      end
    end
  endtask

  vec_t v [11];

  initial begin
    v[0]  = '{0,1,0,0,5'd0,32'h4,32'h1234,      0,0,5'd0,32'h4,32'h0,32'h4,0};
    v[1]  = '{1,0,1,1,5'd3,32'h4,32'h0,         1,1,5'd3,32'h4,32'h1234,32'h1234,0};
    v[2]  = '{0,0,0,1,5'd9,32'h7F,32'h0,        1,0,5'd9,32'h7F,32'h0,32'h7F,0};
    v[3]  = '{1,0,1,1,5'd2,32'h6,32'h0,         0,0,5'd0,32'h0,32'h0,32'h0,1};
    v[4]  = '{1,0,1,1,5'd3,32'h4,32'h0,         1,1,5'd3,32'h4,32'h1234,32'h1234,0};
    v[5]  = '{0,1,0,0,5'd0,32'h400,32'h55,      0,0,5'd0,32'h400,32'h0,32'h400,0};
    v[6]  = '{1,0,1,1,5'd7,32'h0,32'h0,         1,1,5'd7,32'h0,32'h55,32'h55,0};
    v[7]  = '{1,1,1,1,5'd4,32'h4,32'h9999,      1,1,5'd4,32'h4,32'h1234,32'h1234,0};
    v[8]  = '{1,0,1,1,5'd4,32'h4,32'h0,         1,1,5'd4,32'h4,32'h9999,32'h9999,0};
    v[9]  = '{0,1,0,0,5'd0,32'h401,32'hFFFF,    0,0,5'd0,32'h0,32'h0,32'h0,1};
    v[10] = '{1,0,1,1,5'd1,32'h400,32'h0,       1,1,5'd1,32'h400,32'h55,32'h55,0};

    reset = 1'b1;
    for (int k = 0; k < 3; k++) nop(k);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_stall_i%0d", k), 32'(stall[k]), 32'd0);
      chk($sformatf("rst_rw_i%0d", k), 32'(orw[k]), 32'd0);
      chk($sformatf("rst_wd_i%0d", k), owdata[k], 32'd0);
      chk($sformatf("rst_mis_i%0d", k), 32'(omis[k]), 32'd0);
    end
    nxt();

    // Zero-wait instance: one vector per cycle, back to back.
    for (int i = 0; i < 11; i++) begin
      drv(1, v[i].rd, v[i].wr, v[i].mtr, v[i].rw, v[i].dst, v[i].alu, v[i].wd);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall[1]), 32'd0);
      nxt();
      chk($sformatf("v%0d_rw", i), 32'(orw[1]), 32'(v[i].e_rw));
      chk($sformatf("v%0d_mtr", i), 32'(omtr[1]), 32'(v[i].e_mtr));
      chk($sformatf("v%0d_dst", i), 32'(odst[1]), 32'(v[i].e_dst));
      chk($sformatf("v%0d_alu", i), oalu[1], v[i].e_alu);
      chk($sformatf("v%0d_rdata", i), ordata[1], v[i].e_rd);
      chk($sformatf("v%0d_wdata", i), owdata[1], v[i].e_wdata);
      chk($sformatf("v%0d_mis", i), 32'(omis[1]), 32'(v[i].e_mis));
    end
    nop(1);

    // Two wait states: store then load, misaligned load, re-read.
    acc(0, 2, 0, 1, 0, 0, 5'd0, 32'h10, 32'hDEADBEEF);
    chk("sw_rw", 32'(orw[0]), 32'd0);
    chk("sw_alu", oalu[0], 32'h10);
    acc(0, 2, 1, 0, 1, 1, 5'd5, 32'h10, 32'h0);
    chk("lw_rw", 32'(orw[0]), 32'd1);
    chk("lw_dst", 32'(odst[0]), 32'd5);
    chk("lw_rdata", ordata[0], 32'hDEADBEEF);
    chk("lw_wdata", owdata[0], 32'hDEADBEEF);
    acc(0, 0, 1, 0, 1, 1, 5'd6, 32'h13, 32'h0);
    chk("mis_flag", 32'(omis[0]), 32'd1);
    chk("mis_rw", 32'(orw[0]), 32'd0);
    chk("mis_rdata", ordata[0], 32'd0);
    acc(0, 2, 1, 0, 1, 1, 5'd6, 32'h10, 32'h0);
    chk("mis_after_rdata", ordata[0], 32'hDEADBEEF);
    chk("mis_after_dst", 32'(odst[0]), 32'd6);
    nop(0);
    #1;
    chk("nop_stall", 32'(stall[0]), 32'd0);
    nxt();
    chk("nop_rw", 32'(orw[0]), 32'd0);

    // Three wait states: reset during the second stall cycle drops the store.
    acc(2, 3, 0, 1, 0, 0, 5'd0, 32'h20, 32'h11112222);
    drv(2, 0, 1, 0, 0, 5'd0, 32'h20, 32'hAAAA5555);
    #1;
    chk("rw_c0_stall", 32'(stall[2]), 32'd1);
    nxt();
    reset = 1'b1;
    #1;
    chk("rw_c1_stall", 32'(stall[2]), 32'd1);
    nxt();
    reset = 1'b0;
    nop(2);
    #1;
    chk("rst_mid_stall", 32'(stall[2]), 32'd0);
    chk("rst_mid_rw", 32'(orw[2]), 32'd0);
    chk("rst_mid_alu", oalu[2], 32'd0);
    chk("rst_mid_wdata", owdata[2], 32'd0);
    chk("rst_mid_mis", 32'(omis[2]), 32'd0);
    nxt();
    acc(2, 3, 1, 0, 1, 1, 5'd8, 32'h20, 32'h0);
    chk("rst_mid_old", ordata[2], 32'h11112222);
    chk("rst_mid_dst", 32'(odst[2]), 32'd8);
    nop(2);
    nxt();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
